// File: rtl/buzzer_scheduler_if.sv
// Bus between the sensor debounce logic and the buzzer scheduler:
// alarm requests and clock enable in, buzzer drive and status out.
interface buzzer_scheduler_if #(
    parameter int N_REQ = 3
);
    logic             ena;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] buzz;
    logic [2:0]       grant_id;
    logic             busy;
    logic [N_REQ-1:0] done;

    modport master (
        output ena, req,
        input  buzz, grant_id, busy, done
    );

    modport slave (
        input  ena, req,
        output buzz, grant_id, busy, done
    );
endinterface

// File: rtl/buzzer_scheduler.sv
// Round-robin time-sharing of one alarm-burst resource: fixed-length burst on
// one buzzer line, then a fixed silent gap, with per-sensor pending latches.
module buzzer_scheduler #(
    parameter int N_REQ      = 3,
    parameter int ON_CYCLES  = 31,
    parameter int GAP_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    buzzer_scheduler_if.slave   bus
);

    localparam int LW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0] ON_LAST  = 8'(ON_CYCLES);
    localparam logic [7:0] GAP_LAST = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ON   = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t           state_q;
    logic [7:0]       cnt_q;
    logic [LW-1:0]    last_q;
    logic [N_REQ-1:0] pend_q;
    logic [N_REQ-1:0] pend_d;
    logic [N_REQ-1:0] buzz_q;
    logic [N_REQ-1:0] done_q;
    logic [2:0]       grant_q;
    logic             busy_q;

    logic [N_REQ-1:0] eff;
    logic [LW-1:0]    g;
    logic [N_REQ-1:0] g_onehot;
    logic             fire;

    // First set bit of e, searching p+1, p+2, ... with wrap at N_REQ.
    function automatic logic [LW-1:0] rr_pick(input logic [N_REQ-1:0] e,
                                              input logic [LW-1:0]    p);
        logic [LW-1:0] pick;
        logic [LW:0]   sum;
        logic          found;
        pick  = p;
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            sum = {1'b0, p} + (LW+1)'(i);
            if (sum >= (LW+1)'(N_REQ)) begin
                sum = sum - (LW+1)'(N_REQ);
            end
            if (!found && e[sum[LW-1:0]]) begin
                pick  = sum[LW-1:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    always_comb begin
        eff      = pend_q | bus.req;
        g        = rr_pick(eff, last_q);
        g_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << g;
        fire     = (|eff) &&
                   ((state_q == S_IDLE) ||
                    ((state_q == S_GAP) && (cnt_q == GAP_LAST)));
        // The grant consumes the request sample that produced it; a request
        // still held on later cycles re-pends through the normal capture.
        pend_d = pend_q | bus.req;
        if (fire) begin
            pend_d = pend_d & ~g_onehot;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            last_q  <= LW'(N_REQ - 1);
            pend_q  <= '0;
            buzz_q  <= '0;
            done_q  <= '0;
            grant_q <= 3'd0;
            busy_q  <= 1'b0;
        end else if (bus.ena) begin
            pend_q <= pend_d;
            done_q <= '0;
            if (fire) begin
                state_q <= S_ON;
                buzz_q  <= g_onehot;
                grant_q <= 3'(g);
                last_q  <= g;
                cnt_q   <= 8'd1;
                busy_q  <= 1'b1;
            end else begin
                case (state_q)
                    S_ON: begin
                        if (cnt_q == ON_LAST) begin
                            state_q <= S_GAP;
                            buzz_q  <= '0;
                            done_q  <= buzz_q;
                            cnt_q   <= 8'd1;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    S_GAP: begin
                        if (cnt_q == GAP_LAST) begin
                            state_q <= S_IDLE;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.buzz     = buzz_q;
    assign bus.grant_id = grant_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;

endmodule

// File: tb/tb_buzzer_scheduler.sv
// Directed bench for buzzer_scheduler with N_REQ=3, ON_CYCLES=31, GAP_CYCLES=8.
module tb_buzzer_scheduler;

    localparam int N   = 3;
    localparam int ON  = 31;
    localparam int GAP = 8;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    buzzer_scheduler_if #(.N_REQ(N)) bus ();

    buzzer_scheduler #(
        .N_REQ      (N),
        .ON_CYCLES  (ON),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst     = 1'b1;
        bus.req = '0;
        bus.ena = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Entered just after a grant edge; walks the burst and the gap and returns
    // just before the edge that ends the gap. pulse is raised on burst cycle 3.
    task automatic burst_and_gap(input int id, input logic [2:0] pulse);
        logic [2:0] oh;
        oh = 3'b001 << id;
        check_val("grant_buzz", 32'(bus.buzz), 32'(oh));
        check_val("grant_id",   32'(bus.grant_id), 32'(id));
        check_val("grant_busy", 32'(bus.busy), 32'd1);
        check_val("grant_done", 32'(bus.done), 32'd0);
        for (int c = 2; c <= ON; c++) begin
            if (c == 3) bus.req = bus.req | pulse;
            if (c == 4) bus.req = bus.req & ~pulse;
            tick();
            if (bus.buzz !== oh) check_val("burst_buzz", 32'(bus.buzz), 32'(oh));
        end
        tick();
        check_val("end_buzz", 32'(bus.buzz), 32'd0);
        check_val("end_done", 32'(bus.done), 32'(oh));
        for (int c = 2; c <= GAP; c++) begin
            tick();
            if (bus.buzz !== 3'b000 || bus.done !== 3'b000 || bus.busy !== 1'b1)
                check_val("gap_state", {27'd0, bus.busy, bus.done[0], bus.buzz}, 32'h10);
        end
        check_val("gap_last_done", 32'(bus.done), 32'd0);
    endtask

    initial begin
        n_cmp   = 0;
        n_err   = 0;
        rst     = 1'b1;
        bus.ena = 1'b1;
        bus.req = '0;

        // Reset state
        do_reset();
        check_val("rst_buzz",  32'(bus.buzz), 32'd0);
        check_val("rst_grant", 32'(bus.grant_id), 32'd0);
        check_val("rst_busy",  32'(bus.busy), 32'd0);
        check_val("rst_done",  32'(bus.done), 32'd0);

        // Async reset mid-burst discards buzz and pending alarms
        bus.req = 3'b010;
        tick();
        bus.req = 3'b000;
        check_val("mid_buzz_pre", 32'(bus.buzz), 32'b010);
        tick();
        bus.req = 3'b100;
        tick();
        bus.req = 3'b000;
        tick();
        #2 rst = 1'b1;
        #1;
        check_val("async_buzz", 32'(bus.buzz), 32'd0);
        check_val("async_busy", 32'(bus.busy), 32'd0);
        check_val("async_done", 32'(bus.done), 32'd0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check_val("post_rst_busy", 32'(bus.busy), 32'd0);
        check_val("post_rst_buzz", 32'(bus.buzz), 32'd0);

        // Single pulse
        do_reset();
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        burst_and_gap(0, 3'b000);
        tick();
        check_val("single_busy_off", 32'(bus.busy), 32'd0);
        check_val("single_buzz_off", 32'(bus.buzz), 32'd0);
        tick();
        check_val("single_stay_idle", 32'(bus.busy), 32'd0);

        // Simultaneous requests, back-to-back bursts without IDLE
        do_reset();
        bus.req = 3'b111;
        tick();
        bus.req = 3'b000;
        burst_and_gap(0, 3'b000);
        tick();
        burst_and_gap(1, 3'b000);
        tick();
        burst_and_gap(2, 3'b000);
        tick();
        check_val("sim_busy_off", 32'(bus.busy), 32'd0);

        // Held request plus newcomer: order 2, 0, 2, 2
        do_reset();
        bus.req = 3'b100;
        tick();
        burst_and_gap(2, 3'b001);
        tick();
        burst_and_gap(0, 3'b000);
        tick();
        burst_and_gap(2, 3'b000);
        tick();
        burst_and_gap(2, 3'b000);
        bus.req = 3'b000;

        // Enable freeze stretches the burst and ignores req
        do_reset();
        bus.req = 3'b001;
        tick();
        bus.req = 3'b000;
        for (int i = 0; i < 4; i++) tick();
        bus.ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.req = (i == 3) ? 3'b010 : 3'b000;
            tick();
        end
        bus.req = 3'b000;
        check_val("frz_buzz_held", 32'(bus.buzz), 32'b001);
        bus.ena = 1'b1;
        for (int i = 0; i < 26; i++) begin
            tick();
            if (bus.buzz !== 3'b001) check_val("frz_burst_buzz", 32'(bus.buzz), 32'b001);
        end
        tick();
        check_val("frz_end_buzz", 32'(bus.buzz), 32'd0);
        check_val("frz_end_done", 32'(bus.done), 32'b001);
        for (int i = 0; i < 7; i++) tick();
        check_val("frz_gap_busy", 32'(bus.busy), 32'd1);
        tick();
        check_val("frz_no_capture_busy", 32'(bus.busy), 32'd0);
        check_val("frz_no_capture_grant", 32'(bus.grant_id), 32'd0);

        // Pointer wrap: last grant 1, req 011 at the end of the gap -> 0
        do_reset();
        bus.req = 3'b010;
        tick();
        bus.req = 3'b000;
        burst_and_gap(1, 3'b000);
        bus.req = 3'b011;
        tick();
        bus.req = 3'b000;
        burst_and_gap(0, 3'b000);
        tick();
        check_val("wrap_next_grant", 32'(bus.grant_id), 32'd1);
        check_val("wrap_next_buzz",  32'(bus.buzz), 32'b010);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
